// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO, issues them one at a time and returns captured results.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int LAT = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iCmdValid,
    output logic       oCmdReady,
    input  logic [3:0] iCmdA,
    input  logic [3:0] iCmdB,
    input  logic [4:0] iCmdOp,
    output logic [3:0] oAluA,
    output logic [3:0] oAluB,
    output logic [4:0] oAluOp,
    input  logic [3:0] iAluResp,
    input  logic [4:0] iAluFlags,
    output logic       oRspValid,
    input  logic       iRspReady,
    output logic [3:0] oRspData,
    output logic [4:0] oRspFlags,
    output logic [4:0] oRspOp,
    output logic       oRspErr,
    output logic [7:0] oCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} stateE;
    stateE state, stateNext;
    logic [12:0] mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic [LW-1:0] waitCnt;
    logic [12:0] head;
    logic empty, full, push, pop, headLegal, rspFire, capture;
    assign head = mem[rdPtr];
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign headLegal = head[4:0] <= 5'd16;
    assign push = iCmdValid & ~full;
    assign rspFire = (state == HOLD) & iRspReady;
    assign oCmdReady = ~iRst & ~full;
    assign oRspValid = state == HOLD;
    always_comb begin
        pop = ~empty & ((state == IDLE) | rspFire);
        capture = (state == WAIT) & (waitCnt == LW'(1));
        stateNext = pop ? (headLegal ? ISSUE : HOLD) :
                    (state == ISSUE) ? WAIT :
                    capture ? HOLD :
                    rspFire ? IDLE : state;
    end
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else state <= stateNext;
    end
    always_ff @(posedge iClk) begin
        if (push) mem[wrPtr] <= {iCmdA, iCmdB, iCmdOp};
    end
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + PW'(push);
            rdPtr <= rdPtr + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // Illegal opcodes bypass the ALU and become an error response straight away.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oAluA <= '0;
            oAluB <= '0;
            oAluOp <= '0;
            oRspData <= '0;
            oRspFlags <= '0;
            oRspOp <= '0;
            oRspErr <= 1'b0;
            oCount <= '0;
            waitCnt <= '0;
        end else begin
            if (pop & headLegal) begin
                oAluA <= head[12:9];
                oAluB <= head[8:5];
                oAluOp <= head[4:0];
            end
            if (pop & ~headLegal) begin
                oRspData <= '0;
                oRspFlags <= '0;
                oRspOp <= head[4:0];
                oRspErr <= 1'b1;
            end
            if (capture) begin
                oRspData <= iAluResp;
                oRspFlags <= iAluFlags;
                oRspOp <= oAluOp;
                oRspErr <= 1'b0;
            end
            if (state == ISSUE) waitCnt <= LW'(LAT);
            else if (state == WAIT) waitCnt <= waitCnt - LW'(1);
            if (rspFire) oCount <= oCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of the command sequencer against a small registered ALU model.
module tb_alu_cmd_sequencer;
    logic iClk = 1'b0, iRst = 1'b1;
    logic iCmdValid = 1'b0, iRspReady = 1'b0;
    logic [3:0] iCmdA = '0, iCmdB = '0;
    logic [4:0] iCmdOp = '0;
    logic oCmdReady, oRspValid, oRspErr;
    logic [3:0] oAluA, oAluB, oRspData;
    logic [4:0] oAluOp, oRspFlags, oRspOp;
    logic [7:0] oCount;
    logic [3:0] aluResp = '0;
    logic [4:0] aluFlags = '0;
    int checks = 0, errors = 0;

    alu_cmd_sequencer #(.DEPTH(4), .LAT(1)) dut (
        .iClk(iClk), .iRst(iRst), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iCmdA(iCmdA), .iCmdB(iCmdB), .iCmdOp(iCmdOp),
        .oAluA(oAluA), .oAluB(oAluB), .oAluOp(oAluOp),
        .iAluResp(aluResp), .iAluFlags(aluFlags),
        .oRspValid(oRspValid), .iRspReady(iRspReady),
        .oRspData(oRspData), .oRspFlags(oRspFlags), .oRspOp(oRspOp),
        .oRspErr(oRspErr), .oCount(oCount)
    );

    always #5 iClk = ~iClk;

    function automatic logic [3:0] aluF(input logic [3:0] a, input logic [3:0] b, input logic [4:0] op);
        case (op)
            5'd0: aluF = ~a;
            5'd1: aluF = a & b;
            5'd2: aluF = a | b;
            5'd12: aluF = a + b;
            5'd13: aluF = a - b;
            5'd16: aluF = a + 4'd1;
            default: aluF = a ^ b;
        endcase
    endfunction

    always @(posedge iClk) begin
        aluResp <= aluF(oAluA, oAluB, oAluOp);
        aluFlags <= {1'b1, oAluA ^ oAluB};
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic pushCmd(input logic [3:0] a, input logic [3:0] b, input logic [4:0] op);
        iCmdValid = 1'b1;
        iCmdA = a;
        iCmdB = b;
        iCmdOp = op;
        tick();
        iCmdValid = 1'b0;
    endtask

    task automatic getRsp(input logic [3:0] d, input logic [4:0] fl, input logic [4:0] op, input logic err);
        int n = 0;
        while (!oRspValid && n < 20) begin
            tick();
            n++;
        end
        check("rsp_valid", 16'(oRspValid), 16'd1);
        check("rsp_data", 16'(oRspData), 16'(d));
        check("rsp_flags", 16'(oRspFlags), 16'(fl));
        check("rsp_op", 16'(oRspOp), 16'(op));
        check("rsp_err", 16'(oRspErr), 16'(err));
        if (oRspValid) tick();
    endtask

    initial begin
        logic allZero;
        #3;
        check("rst_ready", 16'(oCmdReady), 16'd0);
        check("rst_valid", 16'(oRspValid), 16'd0);
        check("rst_count", 16'(oCount), 16'd0);
        check("rst_alu", {oAluA, oAluB, oAluOp}, 16'd0);
        tick();
        iRst = 1'b0;
        #1;
        check("ready_after_rst", 16'(oCmdReady), 16'd1);
        // single legal op: E0 accept, E1 issue, E3 response
        iRspReady = 1'b1;
        pushCmd(4'd3, 4'd4, 5'd12);
        check("e0_valid", 16'(oRspValid), 16'd0);
        tick();
        check("e1_alu", {3'b0, oAluA, oAluB, oAluOp}, {3'b0, 4'd3, 4'd4, 5'd12});
        check("e1_valid", 16'(oRspValid), 16'd0);
        tick();
        check("e2_valid", 16'(oRspValid), 16'd0);
        tick();
        check("e3_valid", 16'(oRspValid), 16'd1);
        check("e3_data", 16'(oRspData), 16'h7);
        check("e3_flags", 16'(oRspFlags), 16'h17);
        check("e3_op", 16'(oRspOp), 16'd12);
        check("e3_err", 16'(oRspErr), 16'd0);
        tick();
        check("e4_valid", 16'(oRspValid), 16'd0);
        check("e4_count", 16'(oCount), 16'd1);
        // fill FIFO with responses stalled
        iRspReady = 1'b0;
        pushCmd(4'hF, 4'h5, 5'd1);
        pushCmd(4'h8, 4'h1, 5'd2);
        pushCmd(4'h0, 4'h0, 5'd0);
        pushCmd(4'h2, 4'h5, 5'd13);
        check("stall_valid", 16'(oRspValid), 16'd1);
        check("ready_three", 16'(oCmdReady), 16'd1);
        pushCmd(4'h1, 4'h1, 5'd12);
        check("ready_full", 16'(oCmdReady), 16'd0);
        pushCmd(4'h7, 4'h7, 5'd12);
        check("ready_still_full", 16'(oCmdReady), 16'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 16'(oRspValid), 16'd1);
            check("hold_rsp", {2'b0, oRspData, oRspFlags, oRspOp}, {2'b0, 4'h5, 5'h1A, 5'd1});
        end
        iRspReady = 1'b1;
        getRsp(4'h5, 5'h1A, 5'd1, 1'b0);
        getRsp(4'h9, 5'h19, 5'd2, 1'b0);
        getRsp(4'hF, 5'h10, 5'd0, 1'b0);
        getRsp(4'hD, 5'h17, 5'd13, 1'b0);
        getRsp(4'h2, 5'h10, 5'd12, 1'b0);
        repeat (8) tick();
        check("drain_valid", 16'(oRspValid), 16'd0);
        check("drain_count", 16'(oCount), 16'd6);
        check("drain_ready", 16'(oCmdReady), 16'd1);
        // illegal opcode: response at E1, ALU drive untouched
        pushCmd(4'h1, 4'h1, 5'd20);
        tick();
        check("ill_valid", 16'(oRspValid), 16'd1);
        check("ill_err", 16'(oRspErr), 16'd1);
        check("ill_data", 16'(oRspData), 16'd0);
        check("ill_flags", 16'(oRspFlags), 16'd0);
        check("ill_op", 16'(oRspOp), 16'd20);
        check("ill_aluop", 16'(oAluOp), 16'd12);
        tick();
        check("ill_done", 16'(oRspValid), 16'd0);
        check("ill_count", 16'(oCount), 16'd7);
        // asynchronous reset mid-WAIT with two queued
        iRspReady = 1'b0;
        pushCmd(4'h3, 4'h4, 5'd12);
        pushCmd(4'h1, 4'h2, 5'd12);
        pushCmd(4'h5, 4'h5, 5'd12);
        check("wait_alu", 16'(oAluA), 16'h3);
        iRst = 1'b1;
        #1;
        check("arst_ready", 16'(oCmdReady), 16'd0);
        check("arst_outs", {3'b0, oRspValid, oAluA, oAluB, oAluOp}, 16'd0);
        check("arst_rsp", {1'b0, oRspErr, oRspData, oRspFlags, oRspOp}, 16'd0);
        check("arst_count", 16'(oCount), 16'd0);
        tick();
        iRst = 1'b0;
        iRspReady = 1'b1;
        #1;
        check("rel_ready", 16'(oCmdReady), 16'd1);
        allZero = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (oRspValid) allZero = 1'b0;
        end
        check("rel_no_rsp", 16'(allZero), 16'd1);
        check("rel_count", 16'(oCount), 16'd0);
        // counter wrap with Op=16
        for (int i = 0; i < 256; i++) begin
            pushCmd(4'h0, 4'h0, 5'd16);
            getRsp(4'h1, 5'h10, 5'd16, 1'b0);
            if (i == 254) check("count_255", 16'(oCount), 16'd255);
        end
        check("count_wrap", 16'(oCount), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
